instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
Instruction fetch stage; the producer side of the decode interface (instruction address, instruction word, valid).
- Holds the PC and issues single-word requests to instruction memory over a valid/ready request channel.
- Accepts responses and presents registered instruction address, word and valid to decode.
- Handles downstream hold (stall) and jump redirect, squashing in-flight and buffered fetches on redirect.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; first fetch address.

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous reset, active-high
if_jump_en_in  in  1  redirect request from execute
if_jump_addr_in  in  32  redirect target; bits [1:0] ignored (treated as 0)
if_hold_in  in  1  downstream stall; decode outputs must not change while high
imem_req_valid_out  out  1  fetch request valid
imem_req_addr_out  out  32  fetch address, word aligned
imem_req_ready_in  in  1  memory accepts request this cycle
imem_resp_valid_in  in  1  response data valid (exactly one per accepted request, >=1 cycle after acceptance)
imem_resp_data_in  in  32  instruction word
if_instr_addr_out  out  32  address of presented instruction
if_instr_out  out  32  presented instruction word
if_instr_valid_out  out  1  presented instruction valid

Behaviour:
- Reset (rst=1 at edge): pc<=RESET_PC; state<=S_REQ; kill<=0; buffer empty; if_instr_addr_out/if_instr_out<=0; if_instr_valid_out<=0. imem_req_valid_out=0 while rst=1.
- Outstanding requests: at most one.
- Request outputs are functions of state only: imem_req_valid_out=(state==S_REQ); imem_req_addr_out=pc.
- S_REQ: request asserted. On ready: pc_inflight<=pc; go to S_WAIT.
- S_WAIT: wait for response. On resp_valid with kill=0:
  - hold=0: output regs<={pc_inflight, data, valid=1}; pc<=pc_inflight+4 (mod 2^32, wraps 32'hFFFF_FFFC -> 0); go to S_REQ.
  - hold=1: data and pc_inflight go into the 1-entry skid buffer; pc<=pc_inflight+4; go to S_FULL.
- On resp_valid with kill=1: drop data; kill<=0; go to S_REQ.
- S_FULL: no request issued. When hold=0: output regs<=buffer, valid=1; buffer empty; go to S_REQ.
- Output register while hold=0 and no new instruction this cycle: if_instr_valid_out<=0 (bubble); address and instruction may keep old values.
- Output register while hold=1: all three outputs unchanged.
- Jump (highest priority, any state, overrides hold):
  - pc<={if_jump_addr_in[31:2],2'b00}.
  - if_instr_valid_out<=0.
  - Buffer emptied.
  - A response arriving in the same cycle is dropped.
  - Next state:
    - S_WAIT if a request is still outstanding after this cycle (S_WAIT without a same-cycle response, or S_REQ with ready=1 this cycle); kill<=1.
    - Otherwise S_REQ; kill<=0.
- Steady-state throughput with zero hold and single-cycle memory: one instruction per 2 cycles.
- Decode-side latency: instruction visible the cycle after its response.
- Reset mid-fetch: outstanding request abandoned. The memory must not return a response for a request accepted before reset; this is a system requirement. Block state returns to the reset values.

Optional Feature:
Macro IF_PERF_CNT_EN.
- Defined:
  - Adds if_perf_fetch_cnt_out (out, 32): counts instructions delivered with valid=1 to decode, including those delivered from the buffer.
  - Adds if_perf_stall_cnt_out (out, 32): counts cycles with if_hold_in=1 and if_instr_valid_out=1.
  - Both counters reset to 0 and wrap on overflow. Squashed fetches are not counted.
- Not defined: ports and counters absent; behaviour otherwise identical.

Test Plan:
1. Reset release with RESET_PC=32'h100, memory ready=1, response next cycle with words A,B,C -> decode sees (0x100,A), (0x104,B), (0x108,C), each valid for one cycle with one bubble between; req addrs 0x100, 0x104, 0x108.
2. Hold=1 for 3 cycles while the response for 0x104 arrives -> 0x100 stays presented unchanged, no new request during S_FULL; on hold=0, (0x104,B) is presented next cycle and request 0x108 issues.
3. Jump to 32'h203 while request for 0x104 is outstanding -> that response is discarded, valid=0 next cycle, next request addr 0x200, decode then sees (0x200,word).
4. Jump in the same cycle as a response with hold=1 and a full buffer -> buffer and response dropped, valid=0, fetch restarts at target, no stale instruction ever presented.
5. RESET_PC=32'hFFFF_FFFC, sequential fetch -> second request addr 32'h0000_0000.
6. rst asserted while in S_WAIT -> next cycle outputs 0, req_valid=0; after release, request at RESET_PC. With IF_PERF_CNT_EN defined, both counters read 0.

Source files
------------

// File: rtl/instr_fetch_if.sv
// ----------------------------------------------------------------------------
// instr_fetch_if
// Instruction-memory request/response channel between the fetch stage and
// instruction memory.
//
// Signals:
//   imem_req_valid_out  fetch -> mem   request valid
//   imem_req_addr_out   fetch -> mem   word-aligned fetch address
//   imem_req_ready_in   mem -> fetch   memory accepts the request this cycle
//   imem_resp_valid_in  mem -> fetch   response data valid
//   imem_resp_data_in   mem -> fetch   instruction word
//
// Modports: master (fetch stage), slave (instruction memory).
// ----------------------------------------------------------------------------
interface instr_fetch_if;
    logic        imem_req_valid_out;
    logic [31:0] imem_req_addr_out;
    logic        imem_req_ready_in;
    logic        imem_resp_valid_in;
    logic [31:0] imem_resp_data_in;

    modport master (
        output imem_req_valid_out,
        output imem_req_addr_out,
        input  imem_req_ready_in,
        input  imem_resp_valid_in,
        input  imem_resp_data_in
    );

    modport slave (
        input  imem_req_valid_out,
        input  imem_req_addr_out,
        output imem_req_ready_in,
        output imem_resp_valid_in,
        output imem_resp_data_in
    );
endinterface

// File: rtl/instr_fetch.sv
// ----------------------------------------------------------------------------
// instr_fetch
// Instruction fetch stage. Holds the PC, issues one word request at a time to
// instruction memory, and presents registered (address, word, valid) to decode.
// A one-entry skid buffer absorbs a response that arrives while decode holds.
// A jump redirects the PC and squashes any in-flight or buffered fetch.
//
// Ports:
//   clk                 clock, rising edge
//   rst                 synchronous reset, active-high
//   if_jump_en_in       redirect request
//   if_jump_addr_in     redirect target, bits [1:0] ignored
//   if_hold_in          decode stall; decode outputs frozen while high
//   imem                instr_fetch_if.master request/response channel
//   if_instr_addr_out   address of presented instruction
//   if_instr_out        presented instruction word
//   if_instr_valid_out  presented instruction valid
//
// Optional build macro IF_PERF_CNT_EN adds:
//   if_perf_fetch_cnt_out  instructions delivered to decode (wrapping)
//   if_perf_stall_cnt_out  cycles with hold=1 and valid=1 (wrapping)
// ----------------------------------------------------------------------------
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 if_jump_en_in,
    input  logic [31:0]          if_jump_addr_in,
    input  logic                 if_hold_in,
    instr_fetch_if.master        imem,
    output logic [31:0]          if_instr_addr_out,
    output logic [31:0]          if_instr_out,
    output logic                 if_instr_valid_out
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]          if_perf_fetch_cnt_out,
    output logic [31:0]          if_perf_stall_cnt_out
`endif
);

    localparam logic [1:0] S_REQ  = 2'd0;  // request asserted
    localparam logic [1:0] S_WAIT = 2'd1;  // one request outstanding
    localparam logic [1:0] S_FULL = 2'd2;  // skid buffer holds an instruction

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_inflight_q, pc_inflight_d;
    logic        kill_q, kill_d;
    logic [31:0] buf_addr_q, buf_addr_d;
    logic [31:0] buf_data_q, buf_data_d;
    logic [31:0] out_addr_d, out_instr_d;
    logic        out_valid_d;
    logic        deliver;

    logic unused_jump_lsb;
    assign unused_jump_lsb = ^if_jump_addr_in[1:0];

    assign imem.imem_req_valid_out = (state_q == S_REQ) && !rst;
    assign imem.imem_req_addr_out  = pc_q;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pc_inflight_d = pc_inflight_q;
        kill_d        = kill_q;
        buf_addr_d    = buf_addr_q;
        buf_data_d    = buf_data_q;
        out_addr_d    = if_instr_addr_out;
        out_instr_d   = if_instr_out;
        out_valid_d   = if_instr_valid_out;
        deliver       = 1'b0;

        // Without hold, the output defaults to a bubble unless refilled below.
        if (!if_hold_in) begin
            out_valid_d = 1'b0;
        end

        if (if_jump_en_in) begin
            pc_d        = {if_jump_addr_in[31:2], 2'b00};
            out_valid_d = 1'b0;
            // A request still in flight after this edge must have its
            // response discarded.
            if (((state_q == S_WAIT) && !imem.imem_resp_valid_in) ||
                ((state_q == S_REQ) && imem.imem_req_ready_in)) begin
                state_d = S_WAIT;
                kill_d  = 1'b1;
            end else begin
                state_d = S_REQ;
                kill_d  = 1'b0;
            end
        end else begin
            unique case (state_q)
                S_REQ: begin
                    if (imem.imem_req_ready_in) begin
                        pc_inflight_d = pc_q;
                        state_d       = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem.imem_resp_valid_in) begin
                        state_d = S_REQ;
                        if (kill_q) begin
                            kill_d = 1'b0;
                        end else begin
                            pc_d = pc_inflight_q + 32'd4;
                            if (!if_hold_in) begin
                                out_addr_d  = pc_inflight_q;
                                out_instr_d = imem.imem_resp_data_in;
                                out_valid_d = 1'b1;
                                deliver     = 1'b1;
                            end else begin
                                buf_addr_d = pc_inflight_q;
                                buf_data_d = imem.imem_resp_data_in;
                                state_d    = S_FULL;
                            end
                        end
                    end
                end
                S_FULL: begin
                    if (!if_hold_in) begin
                        out_addr_d  = buf_addr_q;
                        out_instr_d = buf_data_q;
                        out_valid_d = 1'b1;
                        deliver     = 1'b1;
                        state_d     = S_REQ;
                    end
                end
                default: state_d = S_REQ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q            <= S_REQ;
            pc_q               <= RESET_PC;
            pc_inflight_q      <= 32'd0;
            kill_q             <= 1'b0;
            buf_addr_q         <= 32'd0;
            buf_data_q         <= 32'd0;
            if_instr_addr_out  <= 32'd0;
            if_instr_out       <= 32'd0;
            if_instr_valid_out <= 1'b0;
        end else begin
            state_q            <= state_d;
            pc_q               <= pc_d;
            pc_inflight_q      <= pc_inflight_d;
            kill_q             <= kill_d;
            buf_addr_q         <= buf_addr_d;
            buf_data_q         <= buf_data_d;
            if_instr_addr_out  <= out_addr_d;
            if_instr_out       <= out_instr_d;
            if_instr_valid_out <= out_valid_d;
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q <= 32'd0;
            stall_cnt_q <= 32'd0;
        end else begin
            if (deliver) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if (if_hold_in && if_instr_valid_out) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign if_perf_fetch_cnt_out = fetch_cnt_q;
    assign if_perf_stall_cnt_out = stall_cnt_q;
`else
    logic unused_deliver;
    assign unused_deliver = deliver;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// ----------------------------------------------------------------------------
// tb_instr_fetch
// Directed scenarios followed by randomized hold/ready/jump/reset traffic.
// A transaction-level model (next fetch address, outstanding flag, a queue
// for the skid buffer, presented instruction) predicts the DUT outputs each
// cycle; a few literal expectations pin the model in the directed part.
// ----------------------------------------------------------------------------
module tb_instr_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic        jump_en;
    logic [31:0] jump_addr;
    logic        hold;
    logic [31:0] instr_addr;
    logic [31:0] instr;
    logic        instr_valid;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch;
    logic [31:0] perf_stall;
`endif

    instr_fetch_if bus ();

    instr_fetch #(.RESET_PC(RST_PC)) dut (
        .clk                (clk),
        .rst                (rst),
        .if_jump_en_in      (jump_en),
        .if_jump_addr_in    (jump_addr),
        .if_hold_in         (hold),
        .imem               (bus),
        .if_instr_addr_out  (instr_addr),
        .if_instr_out       (instr),
        .if_instr_valid_out (instr_valid)
`ifdef IF_PERF_CNT_EN
        ,
        .if_perf_fetch_cnt_out (perf_fetch),
        .if_perf_stall_cnt_out (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit do_check;

    // Memory environment
    bit          mem_pending;
    logic [31:0] mem_addr;
    int          mem_cnt;
    int          mem_lat;
    bit          rand_lat;

    // Behavioural model
    logic [31:0] m_pc;
    logic [31:0] m_inflight;
    bit          m_outstanding;
    bit          m_killed;
    logic [31:0] m_buf_q[$];
    logic [31:0] m_addr;
    logic [31:0] m_instr;
    bit          m_valid;
    logic [31:0] m_fetch;
    logic [31:0] m_stall;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic present(input logic [31:0] a);
        m_addr  = a;
        m_instr = word_of(a);
        m_valid = 1'b1;
        m_fetch = m_fetch + 32'd1;
    endtask

    // One clock cycle: drive inputs, compare at the falling edge, advance the
    // memory and the model at the rising edge.
    task automatic step(input bit r, input bit j, input logic [31:0] ja, input bit h,
                        input bit rdy);
        bit          resp;
        bit          exp_req;
        bit          acc;
        bit          s_req_valid;
        logic [31:0] s_req_addr;
        rst       = r;
        jump_en   = j;
        jump_addr = ja;
        hold      = h;
        bus.imem_req_ready_in  = rdy;
        resp = mem_pending && (mem_cnt == 0) && !r;
        bus.imem_resp_valid_in = resp;
        bus.imem_resp_data_in  = resp ? word_of(mem_addr) : 32'hDEAD_BEEF;
        #4;
        exp_req     = !r && !m_outstanding && (m_buf_q.size() == 0);
        s_req_valid = bus.imem_req_valid_out;
        s_req_addr  = bus.imem_req_addr_out;
        if (do_check) begin
            chk("req_valid", 32'(s_req_valid), 32'(exp_req));
            if (exp_req) chk("req_addr", s_req_addr, m_pc);
            chk("instr_valid", 32'(instr_valid), 32'(m_valid));
            if (m_valid) begin
                chk("instr_addr", instr_addr, m_addr);
                chk("instr_word", instr, m_instr);
            end
`ifdef IF_PERF_CNT_EN
            chk("perf_fetch", perf_fetch, m_fetch);
            chk("perf_stall", perf_stall, m_stall);
`endif
        end
        @(posedge clk);
        if (r) begin
            mem_pending = 1'b0;
        end else begin
            if (resp) mem_pending = 1'b0;
            else if (mem_pending) mem_cnt--;
            if (s_req_valid && rdy) begin
                mem_pending = 1'b1;
                mem_addr    = s_req_addr;
                mem_cnt     = rand_lat ? int'($urandom_range(0, 3)) : mem_lat;
            end
        end
        acc = exp_req && rdy;
        if (r) begin
            m_pc          = RST_PC;
            m_outstanding = 1'b0;
            m_killed      = 1'b0;
            m_buf_q.delete();
            m_addr        = 32'd0;
            m_instr       = 32'd0;
            m_valid       = 1'b0;
            m_fetch       = 32'd0;
            m_stall       = 32'd0;
        end else begin
            if (h && m_valid) m_stall = m_stall + 32'd1;
            if (j) begin
                m_pc          = {ja[31:2], 2'b00};
                m_valid       = 1'b0;
                m_buf_q.delete();
                m_outstanding = (m_outstanding && !resp) || acc;
                m_killed      = m_outstanding;
            end else begin
                if (!h) m_valid = 1'b0;
                if (acc) begin
                    m_outstanding = 1'b1;
                    m_inflight    = m_pc;
                end
                if (resp) begin
                    m_outstanding = 1'b0;
                    if (m_killed) begin
                        m_killed = 1'b0;
                    end else begin
                        m_pc = m_inflight + 32'd4;
                        if (!h) present(m_inflight);
                        else m_buf_q.push_back(m_inflight);
                    end
                end else if (m_buf_q.size() != 0 && !h) begin
                    present(m_buf_q.pop_front());
                end
            end
        end
        #1;
    endtask

    initial begin
        rst = 1'b1; jump_en = 1'b0; jump_addr = 32'd0; hold = 1'b0;
        bus.imem_req_ready_in = 1'b0;
        bus.imem_resp_valid_in = 1'b0;
        bus.imem_resp_data_in = 32'd0;
        mem_pending = 1'b0; mem_addr = 32'd0; mem_cnt = 0; mem_lat = 0; rand_lat = 1'b0;
        m_pc = RST_PC; m_inflight = 32'd0; m_outstanding = 1'b0; m_killed = 1'b0;
        m_addr = 32'd0; m_instr = 32'd0; m_valid = 1'b0; m_fetch = 32'd0; m_stall = 32'd0;
        do_check = 1'b0;
        #1;

        // Reset
        step(1, 0, 0, 0, 0);
        do_check = 1'b1;
        step(1, 0, 0, 0, 0);
        chk("lit_rst_valid", 32'(instr_valid), 32'd0);
        chk("lit_rst_pc", bus.imem_req_addr_out, 32'h100);

        // Sequential fetch, single-cycle memory
        step(0, 0, 0, 0, 1);
        chk("lit_wait_noreq", 32'(bus.imem_req_valid_out), 32'd0);
        step(0, 0, 0, 0, 1);
        chk("lit_a_valid", 32'(instr_valid), 32'd1);
        chk("lit_a_addr", instr_addr, 32'h100);
        chk("lit_a_word", instr, word_of(32'h100));
        chk("lit_next_req", bus.imem_req_addr_out, 32'h104);
        step(0, 0, 0, 0, 1);
        chk("lit_bubble", 32'(instr_valid), 32'd0);
        step(0, 0, 0, 0, 1);
        chk("lit_b_addr", instr_addr, 32'h104);

        // Hold while the next response lands in the skid buffer
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 1, 1);
        chk("lit_full_noreq", 32'(bus.imem_req_valid_out), 32'd0);
        chk("lit_hold_addr", instr_addr, 32'h104);
        step(0, 0, 0, 1, 1);
        chk("lit_hold_valid", 32'(instr_valid), 32'd1);
        step(0, 0, 0, 0, 1);
        chk("lit_buf_addr", instr_addr, 32'h108);
        chk("lit_buf_req", bus.imem_req_addr_out, 32'h10C);

        // Jump while a request is outstanding
        mem_lat = 1;
        step(0, 0, 0, 0, 1);
        step(0, 1, 32'h203, 0, 1);
        chk("lit_jmp_valid", 32'(instr_valid), 32'd0);
        chk("lit_jmp_pc", bus.imem_req_addr_out, 32'h200);
        step(0, 0, 0, 0, 1);
        chk("lit_killed_valid", 32'(instr_valid), 32'd0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        chk("lit_tgt_addr", instr_addr, 32'h200);
        chk("lit_tgt_word", instr, word_of(32'h200));

        // Jumps under hold: with a full buffer, then with a same-cycle response
        mem_lat = 0;
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 1, 1);
        step(0, 1, 32'h300, 1, 1);
        chk("lit_full_jmp_valid", 32'(instr_valid), 32'd0);
        chk("lit_full_jmp_pc", bus.imem_req_addr_out, 32'h300);
        step(0, 0, 0, 1, 1);
        step(0, 1, 32'h400, 1, 1);
        chk("lit_resp_jmp_pc", bus.imem_req_addr_out, 32'h400);
        chk("lit_resp_jmp_req", 32'(bus.imem_req_valid_out), 32'd1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        chk("lit_400_addr", instr_addr, 32'h400);

        // PC wrap
        step(0, 1, 32'hFFFF_FFFC, 0, 0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        chk("lit_wrap_addr", instr_addr, 32'hFFFF_FFFC);
        chk("lit_wrap_pc", bus.imem_req_addr_out, 32'h0);

        // Reset while waiting
        mem_lat = 2;
        step(0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0);
        chk("lit_midrst_valid", 32'(instr_valid), 32'd0);
        chk("lit_midrst_addr", instr_addr, 32'd0);
        chk("lit_midrst_req", 32'(bus.imem_req_valid_out), 32'd0);
        chk("lit_midrst_pc", bus.imem_req_addr_out, 32'h100);
`ifdef IF_PERF_CNT_EN
        chk("lit_midrst_pf", perf_fetch, 32'd0);
        chk("lit_midrst_ps", perf_stall, 32'd0);
`endif
        step(0, 0, 0, 0, 1);

        // Random traffic
        rand_lat = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 19) == 0), $urandom,
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 4) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
